// File: rtl/gpu_fb_scanout_pkg.sv
// Shared widths, defaults and types for the frame-buffer scanout block.
// Widths are sized for 640x480; smaller rasters fit in the same fields.
package gpu_fb_scanout_pkg;
  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;
  localparam int RGB_BITS     = 3 * CHANNEL_BITS;
  localparam int ADDR_BITS    = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam int OFFSETMEM    = 307200;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAP} scan_state_t;

  typedef struct packed {
    logic [RGB_BITS-1:0]    rgb;
    logic [WIDTH_BITS-1:0]  x;
    logic [HEIGHT_BITS-1:0] y;
  } pix_t;
endpackage

// File: rtl/gpu_pix_fifo.sv
// Small synchronous FIFO between the SRAM reader and the display timing block.
// A push is accepted when full only if a pop happens on the same edge.
module gpu_pix_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/gpu_fb_scanout.sv
// Scans the front half of the double-buffered SRAM in raster order and queues
// {rgb,x,y} pixels; buffer swaps requested by flush_i take effect at the frame wrap.
module gpu_fb_scanout
  import gpu_fb_scanout_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int BUF1_BASE  = OFFSETMEM,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   enable_i,
  input  logic                   flush_i,
  input  logic [RGB_BITS-1:0]    rgbdata_i,
  output logic                   CE0_o,
  output logic                   CE1_o,
  output logic                   OE_o,
  output logic                   R_W_o,
  output logic                   LB_o,
  output logic                   UB_o,
  output logic                   SEM_o,
  output logic                   ZZ_o,
  output logic [ADDR_BITS-1:0]   addr_o,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic [RGB_BITS-1:0]    rgb_o,
  output logic [WIDTH_BITS-1:0]  x_o,
  output logic [HEIGHT_BITS-1:0] y_o,
  output logic                   frame_start_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  scan_state_t            state_q, state_d;
  logic [WIDTH_BITS-1:0]  x_q, x_d;
  logic [HEIGHT_BITS-1:0] y_q, y_d;
  logic [ADDR_BITS-1:0]   row_base_q, row_base_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   front_sel_q, front_sel_d;
  logic                   swap_pend_q, swap_pend_d;
  logic                   rd_en_q, rd_en_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   push;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count, slots_free;
  logic                   in_flight, start_ok;
  pix_t                   push_pix, head_pix;

  // A new read needs a FIFO slot beyond the one the in-flight read will use.
  assign in_flight  = (state_q != IDLE);
  assign slots_free = CW'(FIFO_DEPTH) - fifo_count;
  assign start_ok   = enable_i && !fifo_full && (slots_free > {{(CW-1){1'b0}}, in_flight});

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row_base_d  = row_base_q;
    addr_d      = addr_q;
    front_sel_d = front_sel_q;
    swap_pend_d = swap_pend_q | flush_i;
    wait_cnt_d  = wait_cnt_q;
    push        = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = REQ;
      REQ: begin
        wait_cnt_d = '0;
        state_d    = (READ_LAT == 1) ? CAP : WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 8'(READ_LAT - 2)) state_d = CAP;
        else wait_cnt_d = wait_cnt_q + 8'd1;
      end
      CAP: begin
        push    = 1'b1;
        state_d = start_ok ? REQ : IDLE;
        if (x_q == WIDTH_BITS'(WIDTH - 1)) begin
          x_d = '0;
          if (y_q == HEIGHT_BITS'(HEIGHT - 1)) begin
            y_d        = '0;
            row_base_d = '0;
            // A flush landing on the wrap cycle still swaps at this wrap.
            if (swap_pend_q || flush_i) begin
              front_sel_d = ~front_sel_q;
              swap_pend_d = 1'b0;
            end
          end else begin
            y_d        = y_q + HEIGHT_BITS'(1);
            row_base_d = row_base_q + ADDR_BITS'(WIDTH);
          end
        end else begin
          x_d = x_q + WIDTH_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == REQ)
      addr_d = row_base_d + ADDR_BITS'(x_d) + (front_sel_d ? ADDR_BITS'(BUF1_BASE) : '0);
    rd_en_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      addr_q      <= '0;
      front_sel_q <= 1'b1;
      swap_pend_q <= 1'b0;
      rd_en_q     <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      addr_q      <= addr_d;
      front_sel_q <= front_sel_d;
      swap_pend_q <= swap_pend_d;
      rd_en_q     <= rd_en_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign CE0_o  = ~rd_en_q;
  assign CE1_o  = rd_en_q;
  assign OE_o   = ~rd_en_q;
  assign LB_o   = ~rd_en_q;
  assign UB_o   = ~rd_en_q;
  assign R_W_o  = 1'b1;
  assign SEM_o  = 1'b1;
  assign ZZ_o   = 1'b0;
  assign addr_o = addr_q;

  assign push_pix = '{rgb: rgbdata_i, x: x_q, y: y_q};

  // Output handshake: a pixel transfers on any edge where pix_valid_o && pix_ready_i.
  gpu_pix_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(pix_t))
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (push),
    .pop_i   (pix_ready_i),
    .wdata_i (push_pix),
    .rdata_o (head_pix),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pix_valid_o   = ~fifo_empty;
  assign rgb_o         = head_pix.rgb;
  assign x_o           = head_pix.x;
  assign y_o           = head_pix.y;
  assign frame_start_o = pix_valid_o && (head_pix.x == '0) && (head_pix.y == '0);
endmodule

// File: tb/tb_gpu_fb_scanout.sv
// Directed bench for gpu_fb_scanout on a 16x6 raster (buffer 1 at 96) with a
// pattern SRAM whose data equals its address, two cycles after the read starts.
module tb_gpu_fb_scanout;
  import gpu_fb_scanout_pkg::*;

  localparam int W  = 16;
  localparam int H  = 6;
  localparam int B1 = 96;
  localparam logic [7:0] CTRL_IDLE = 8'b1011_1110;
  localparam logic [7:0] CTRL_READ = 8'b0101_0010;

  logic                   clk = 1'b0;
  logic                   n_rst = 1'b0;
  logic                   enable_i = 1'b0;
  logic                   flush_i = 1'b0;
  logic                   pix_ready_i = 1'b0;
  logic [RGB_BITS-1:0]    rgbdata_i;
  logic                   CE0_o, CE1_o, OE_o, R_W_o, LB_o, UB_o, SEM_o, ZZ_o;
  logic [ADDR_BITS-1:0]   addr_o;
  logic                   pix_valid_o, frame_start_o;
  logic [RGB_BITS-1:0]    rgb_o;
  logic [WIDTH_BITS-1:0]  x_o;
  logic [HEIGHT_BITS-1:0] y_o;
  logic [7:0]             ctrl;
  logic [23:0]            rd_pipe [2] = '{24'h0, 24'h0};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int m_x = 0, m_y = 0, m_buf = 1;
  bit m_pend = 1'b0;

  gpu_fb_scanout #(
    .WIDTH(W), .HEIGHT(H), .BUF1_BASE(B1), .READ_LAT(2), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .n_rst(n_rst), .enable_i(enable_i), .flush_i(flush_i),
    .rgbdata_i(rgbdata_i),
    .CE0_o(CE0_o), .CE1_o(CE1_o), .OE_o(OE_o), .R_W_o(R_W_o),
    .LB_o(LB_o), .UB_o(UB_o), .SEM_o(SEM_o), .ZZ_o(ZZ_o),
    .addr_o(addr_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .rgb_o(rgb_o), .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  assign ctrl = {CE0_o, CE1_o, OE_o, R_W_o, LB_o, UB_o, SEM_o, ZZ_o};

  // Pattern SRAM: data is the address, but only when the port is actually enabled.
  always @(posedge clk) begin
    rd_pipe[0] <= (!CE0_o && CE1_o && !OE_o) ? 24'(addr_o) : 24'hBAD000;
    rd_pipe[1] <= rd_pipe[0];
  end
  assign rgbdata_i = rd_pipe[1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream of popped pixels, from a raster model of the scan.
  task automatic monitor();
    logic [63:0] exp_v;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        m_x = 0; m_y = 0; m_buf = 1; m_pend = 1'b0;
      end else begin
        if (flush_i) m_pend = 1'b1;
        if (pix_valid_o && pix_ready_i) begin
          exp_v = {20'd0, 24'(m_buf * B1 + m_y * W + m_x), 10'(m_x), 9'(m_y),
                   (m_x == 0 && m_y == 0)};
          check("pixel", {20'd0, rgb_o, x_o, y_o, frame_start_o}, exp_v);
          if (m_x == W - 1) begin
            m_x = 0;
            if (m_y == H - 1) begin
              m_y = 0;
              if (m_pend) begin m_buf = 1 - m_buf; m_pend = 1'b0; end
            end else m_y++;
          end else m_x++;
        end
      end
    end
  endtask

  task automatic wait_req(input logic [ADDR_BITS-1:0] a, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (ctrl == CTRL_READ && addr_o == a) ok = 1'b1;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_head(input int x, input int y, input int rgb, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (pix_valid_o && x_o == 10'(x) && y_o == 9'(y)) ok = 1'b1;
    end
    check({tag, "_found"}, 64'(ok), 64'd1);
    check({tag, "_rgb"}, 64'(rgb_o), 64'(rgb));
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
  endtask

  initial begin
    fork monitor(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
    check("rst_addr", 64'(addr_o), 64'd0);
    check("rst_valid", 64'(pix_valid_o), 64'd0);
    check("rst_fstart", 64'(frame_start_o), 64'd0);

    // Start on buffer 1 with the consumer stalled: one read per 3 cycles, 8 reads then park
    #2 n_rst = 1'b1; enable_i = 1'b1;
    wait_req(20'(B1), 20, "first_addr");
    check("req_ctrl", 64'(ctrl), 64'(CTRL_READ));
    @(negedge clk);
    check("wait_ctrl", 64'(ctrl), 64'(CTRL_READ));
    @(negedge clk);
    check("cap_ctrl", 64'(ctrl), 64'(CTRL_READ));
    @(negedge clk);
    check("addr_97", 64'(addr_o), 64'd97);
    repeat (3) @(negedge clk);
    check("addr_98", 64'(addr_o), 64'd98);
    repeat (94) @(negedge clk);
    check("full_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
    check("full_last_addr", 64'(addr_o), 64'd103);
    check("full_valid", 64'(pix_valid_o), 64'd1);
    check("full_head", 64'({rgb_o, x_o, y_o, frame_start_o}),
          64'({24'd96, 10'd0, 9'd0, 1'b1}));

    // Release the consumer; row_base steps by W between lines
    @(posedge clk); #1 pix_ready_i = 1'b1;
    wait_head(15, 0, 111, "end_of_row0");
    wait_head(0, 1, 112, "start_of_row1");

    // Flush mid-frame twice; exactly one swap at the wrap
    wait_head(0, 2, 128, "row2");
    pulse_flush();
    repeat (10) @(negedge clk);
    pulse_flush();
    wait_req(20'(B1 + W * H - 1), 1500, "buf1_last_addr");
    repeat (3) @(negedge clk);
    check("swap_addr", 64'(addr_o), 64'd0);
    check("swap_ctrl", 64'(ctrl), 64'(CTRL_READ));

    // Drop enable during WAIT: the read completes, then park; resume at the next pixel
    @(negedge clk);
    enable_i = 1'b0;
    check("drop_wait_ctrl", 64'(ctrl), 64'(CTRL_READ));
    @(negedge clk);
    check("drop_cap_ctrl", 64'(ctrl), 64'(CTRL_READ));
    @(negedge clk);
    check("drop_idle_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
    repeat (20) @(negedge clk);
    check("parked_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
    enable_i = 1'b1;
    wait_req(20'd1, 10, "resume_addr");

    // Second flush must not have queued another swap
    wait_req(20'(W * H - 1), 1000, "buf0_last_addr");
    repeat (3) @(negedge clk);
    check("no_extra_swap_addr", 64'(addr_o), 64'd0);

    // Asynchronous reset in the middle of a read
    wait_req(20'd1, 10, "pre_reset_addr");
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
    check("async_rst_addr", 64'(addr_o), 64'd0);
    check("async_rst_valid", 64'(pix_valid_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 n_rst = 1'b1;
    wait_req(20'(B1), 20, "restart_addr");
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
